// File: rtl/snake_pkg.sv
// Shared types and constants for the playfield redraw path.
// The grid is 16x12 cells and each draw command is an 11-bit {x, y, code} word.
package snake_pkg;

    typedef enum logic [2:0] {
        OBJ_EMPTY  = 3'd0,
        OBJ_HEAD   = 3'd1,
        OBJ_BODY   = 3'd2,
        OBJ_APPLE  = 3'd3,
        OBJ_BORDER = 3'd4
    } obj_code_t;

    localparam int GRID_COLS = 16;
    localparam int GRID_ROWS = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic [3:0] x;
        logic [3:0] y;
        obj_code_t  code;
    } draw_cmd_t;

    function automatic draw_cmd_t make_cmd(input logic [3:0] x, input logic [3:0] y,
                                           input obj_code_t code);
        draw_cmd_t c;
        c.x    = x;
        c.y    = y;
        c.code = code;
        return c;
    endfunction

endpackage

// File: rtl/cell_redraw_scheduler_if.sv
// Valid/ready draw-command channel from the scheduler to the display writer.
interface cell_redraw_scheduler_if;
    import snake_pkg::*;

    logic       draw_valid;
    logic       draw_ready;
    logic [3:0] draw_x;
    logic [3:0] draw_y;
    obj_code_t  draw_code;

    modport master (output draw_valid, output draw_x, output draw_y, output draw_code,
                    input  draw_ready);
    modport slave  (input  draw_valid, input  draw_x, input  draw_y, input  draw_code,
                    output draw_ready);
endinterface

// File: rtl/cell_redraw_scheduler_draw_cmd_fifo.sv
// First-word-fall-through FIFO for draw commands.
// The read port shows zero while the FIFO is empty.
module draw_cmd_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      nrst,
    input  logic      push_i,
    input  logic      pop_i,
    input  draw_cmd_t wdata_i,
    output draw_cmd_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    draw_cmd_t   mem_q [DEPTH];
    logic        do_push_s;
    logic        do_pop_s;

    // Pointers carry one extra wrap bit to tell full from empty.
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o   = (wr_q == rd_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push_s) wr_q <= wr_q + PTR_ONE;
            if (do_pop_s)  rd_q <= rd_q + PTR_ONE;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
endmodule

// File: rtl/cell_redraw_scheduler.sv
// Per-frame cell scan: walks the frame tracker one cell at a time and queues redraw commands
// for changed cells (or every cell in force mode) toward the display writer.
module cell_redraw_scheduler
    import snake_pkg::*;
#(
    parameter int COLS       = GRID_COLS,
    parameter int ROWS       = GRID_ROWS,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic                    tick,
    input  logic                    force_all,
    input  logic                    trk_diff,
    input  logic [3:0]              trk_x,
    input  logic [3:0]              trk_y,
    input  obj_code_t               trk_code,
    output logic                    trk_enable,
    cell_redraw_scheduler_if.master draw,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    overrun
);
    localparam logic [7:0] LAST_CELL = 8'(COLS * ROWS - 1);

    sched_state_t state_q;
    logic [7:0]   cnt_q;
    logic         pend_q;
    logic         force_q;
    logic         frame_done_q;
    logic         overrun_q;

    logic         full_s;
    logic         empty_s;
    logic         push_s;
    logic         pop_s;
    draw_cmd_t    head_s;

    // A full FIFO stalls the tracker, even when a pop frees a slot in the same cycle.
    assign trk_enable      = (state_q == ST_SCAN) && !full_s;
    assign push_s          = trk_enable && (trk_diff || force_q);
    assign pop_s           = draw.draw_valid && draw.draw_ready;
    assign draw.draw_valid = !empty_s;
    assign draw.draw_x     = head_s.x;
    assign draw.draw_y     = head_s.y;
    assign draw.draw_code  = head_s.code;
    assign busy            = (state_q != ST_IDLE);
    assign frame_done      = frame_done_q;
    assign overrun         = overrun_q;

    draw_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .nrst    (nrst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (make_cmd(trk_x, trk_y, trk_code)),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // Frame sequencing, tick bookkeeping and the one-cycle status pulses.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            pend_q       <= 1'b0;
            force_q      <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick || pend_q) begin
                        // A fresh tick landing alongside a pending one stays queued.
                        force_q <= force_all;
                        pend_q  <= tick && pend_q;
                        cnt_q   <= 8'd0;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (tick) begin
                        overrun_q <= pend_q;
                        pend_q    <= 1'b1;
                    end
                    if (trk_enable) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (cnt_q == LAST_CELL) state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (tick) begin
                        overrun_q <= pend_q;
                        pend_q    <= 1'b1;
                    end
                    if (empty_s) begin
                        frame_done_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cell_redraw_scheduler.sv
// Bench for cell_redraw_scheduler: a behavioural tracker plus a per-frame expected-command
// queue computed from the cell diff map, with table-driven frames and hand-written corner sequences.
module tb_cell_redraw_scheduler;
    import snake_pkg::*;

    localparam int NCELL = 192;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       tick = 1'b0;
    logic       force_all = 1'b0;
    logic       trk_diff;
    logic [3:0] tx, ty;
    obj_code_t  trk_code;
    logic       trk_enable, busy, frame_done, overrun;

    cell_redraw_scheduler_if dif ();

    cell_redraw_scheduler #(.COLS(16), .ROWS(12), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .tick       (tick),
        .force_all  (force_all),
        .trk_diff   (trk_diff),
        .trk_x      (tx),
        .trk_y      (ty),
        .trk_code   (trk_code),
        .trk_enable (trk_enable),
        .draw       (dif),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Frame content and a tracker that steps through it in raster order.
    bit        diff_a [NCELL];
    obj_code_t code_a [NCELL];

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tx <= 4'd0;
            ty <= 4'd0;
        end else if (trk_enable) begin
            if (tx == 4'd15) begin
                tx <= 4'd0;
                ty <= (ty == 4'd11) ? 4'd0 : ty + 4'd1;
            end else begin
                tx <= tx + 4'd1;
            end
        end
    end
    assign trk_diff = diff_a[{ty, tx}];
    assign trk_code = code_a[{ty, tx}];

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard state shared with the monitor.
    logic [10:0] exp_q[$];
    bit          cur_force = 1'b0;
    int          occ = 0;
    int          en_cnt = 0;
    int          hs_cnt = 0;
    int          frames = 0;
    int          ovr_cnt = 0;
    bit          pend_expected = 1'b0;
    bit          restart_chk = 1'b0;
    bit          hold_v = 1'b0;
    logic [10:0] hold_val;

    // Per-frame expectation straight from the rule: raster order, every cell if forced, else changed cells.
    task automatic build_expected(input bit f);
        for (int c = 0; c < NCELL; c++)
            if (f || diff_a[c]) exp_q.push_back({4'(c % 16), 4'(c / 16), code_a[c]});
    endtask

    task automatic set_pattern(input int pat);
        for (int c = 0; c < NCELL; c++) begin
            code_a[c] = obj_code_t'($urandom_range(0, 4));
            case (pat)
                1:       diff_a[c] = (c == 35) || (c == 87);
                2:       diff_a[c] = (c % 2 == 0);
                3:       diff_a[c] = ($urandom_range(0, 2) == 0);
                default: diff_a[c] = 1'b0;
            endcase
        end
        if (pat == 1) begin
            code_a[35] = OBJ_HEAD;
            code_a[87] = OBJ_APPLE;
        end
    endtask

    // Monitor: sampled mid-cycle, checks handshake data, occupancy and frame pulses.
    initial begin
        forever begin
            @(negedge clk);
            if (!nrst) begin
                occ = 0;
                hold_v = 1'b0;
                restart_chk = 1'b0;
            end else begin
                if (hold_v && dif.draw_valid)
                    check("hold_stable", {dif.draw_x, dif.draw_y, dif.draw_code}, hold_val);
                hold_v = dif.draw_valid && !dif.draw_ready;
                hold_val = {dif.draw_x, dif.draw_y, dif.draw_code};
                check("valid_vs_occupancy", dif.draw_valid, occ != 0);
                if (dif.draw_valid && dif.draw_ready) begin
                    hs_cnt++;
                    occ--;
                    if (exp_q.size() == 0) check("unexpected_cmd", {dif.draw_x, dif.draw_y, dif.draw_code}, 32'hFFFF);
                    else check("cmd_order", {dif.draw_x, dif.draw_y, dif.draw_code}, exp_q.pop_front());
                end
                if (trk_enable) begin
                    en_cnt++;
                    check("no_enable_when_full", occ - (dif.draw_valid && dif.draw_ready ? -1 : 0) < DEPTH, 1);
                    if (trk_diff || cur_force) occ++;
                end
                if (restart_chk) begin
                    check("restart_next_cycle", busy, 1);
                    restart_chk = 1'b0;
                end
                if (overrun) ovr_cnt++;
                if (frame_done) begin
                    frames++;
                    check("busy_low_at_done", busy, 0);
                    check("fifo_empty_at_done", occ == 0, 1);
                    if (pend_expected) begin
                        restart_chk = 1'b1;
                        pend_expected = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic ready_of(input int mode, input int cyc);
        case (mode)
            1:       return cyc % 2 == 0;
            2:       return $urandom_range(0, 1) == 1;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_frame(input bit f, input int mode, input int stall, input int exp_n, input string nm);
        int f0;
        int cyc;
        f0 = frames;
        en_cnt = 0;
        hs_cnt = 0;
        build_expected(f);
        cur_force = f;
        @(posedge clk); #1;
        tick = 1'b1;
        force_all = f;
        dif.draw_ready = (stall > 0) ? 1'b0 : ready_of(mode, 0);
        @(posedge clk); #1;
        tick = 1'b0;
        force_all = 1'b0;
        cyc = 0;
        while (frames == f0 && cyc < 4000) begin
            if (stall > 0 && cyc == stall) begin
                check({nm, "_stall_enable"}, trk_enable, 0);
                check({nm, "_stall_trk_xy"}, {ty, tx}, 8'h04);
                check({nm, "_stall_head"}, {dif.draw_valid, dif.draw_x, dif.draw_y, dif.draw_code},
                      {1'b1, 8'h00, code_a[0]});
            end
            dif.draw_ready = (cyc < stall) ? 1'b0 : ready_of(mode, cyc);
            @(posedge clk); #1;
            cyc++;
        end
        dif.draw_ready = 1'b1;
        check({nm, "_frame_done"}, frames - f0, 1);
        check({nm, "_cmd_count"}, hs_cnt, exp_n);
        check({nm, "_enable_cycles"}, en_cnt, NCELL);
        check({nm, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        bit f;
        int pat;
        int mode;
        int stall;
        int exp_n;
    } vec_t;
    vec_t vt[6];

    initial begin
        int f0;
        int ndiff;
        vt[0] = '{f: 1'b1, pat: 0, mode: 0, stall: 0,  exp_n: 192};
        vt[1] = '{f: 1'b0, pat: 1, mode: 0, stall: 0,  exp_n: 2};
        vt[2] = '{f: 1'b0, pat: 0, mode: 0, stall: 0,  exp_n: 0};
        vt[3] = '{f: 1'b0, pat: 2, mode: 1, stall: 0,  exp_n: 96};
        vt[4] = '{f: 1'b1, pat: 0, mode: 0, stall: 12, exp_n: 192};
        vt[5] = '{f: 1'b1, pat: 1, mode: 2, stall: 0,  exp_n: 192};
        dif.draw_ready = 1'b1;
        set_pattern(0);

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {trk_enable, dif.draw_valid, dif.draw_x, dif.draw_y, dif.draw_code,
                                busy, frame_done, overrun}, 16'h0000);
        nrst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset", {trk_enable, dif.draw_valid, busy, frame_done, overrun}, 5'd0);

        for (int i = 0; i < 6; i++) begin
            set_pattern(vt[i].pat);
            run_frame(vt[i].f, vt[i].mode, vt[i].stall, vt[i].exp_n, $sformatf("vec%0d", i));
        end

        for (int r = 0; r < 3; r++) begin
            set_pattern(3);
            ndiff = 0;
            for (int c = 0; c < NCELL; c++) ndiff += diff_a[c];
            run_frame(1'b0, 2, 0, ndiff, $sformatf("rand%0d", r));
        end

        // Ticks during a scan: the second is held pending, the third overruns.
        set_pattern(1);
        cur_force = 1'b0;
        en_cnt = 0;
        hs_cnt = 0;
        f0 = frames;
        ovr_cnt = 0;
        build_expected(1'b0);
        build_expected(1'b0);
        pend_expected = 1'b1;
        dif.draw_ready = 1'b1;
        for (int cyc = 0; cyc < 1500 && frames < f0 + 2; cyc++) begin
            tick = (cyc == 0) || (cyc == 6) || (cyc == 10);
            @(posedge clk); #1;
        end
        tick = 1'b0;
        check("pend_two_frames", frames - f0, 2);
        check("pend_overrun_count", ovr_cnt, 1);
        check("pend_cmd_count", hs_cnt, 4);
        check("pend_enable_cycles", en_cnt, 2 * NCELL);
        repeat (20) @(posedge clk);
        #1;
        check("pend_no_third_frame", {frames - f0, 31'(busy)}, {32'd2, 31'd0});
        exp_q.delete();

        // Reset in the middle of a forced scan.
        set_pattern(0);
        cur_force = 1'b1;
        en_cnt = 0;
        f0 = frames;
        build_expected(1'b1);
        @(posedge clk); #1;
        tick = 1'b1;
        force_all = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        force_all = 1'b0;
        for (int cyc = 0; cyc < 300 && en_cnt < 50; cyc++) begin
            @(posedge clk); #1;
        end
        check("midscan_reached_50", en_cnt >= 50, 1);
        nrst = 1'b0;
        #1;
        check("midscan_reset_outputs", {trk_enable, dif.draw_valid, dif.draw_x, dif.draw_y, dif.draw_code,
                                        busy, frame_done, overrun}, 16'h0000);
        exp_q.delete();
        @(posedge clk); #1;
        nrst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midscan_no_frame_done", frames - f0, 0);
        check("midscan_idle", {busy, dif.draw_valid}, 2'b00);
        run_frame(1'b1, 0, 0, 192, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
